// File: rtl/layer_pkg.sv
// rtl/layer_pkg.sv - shared element and FIFO word types for the layer datapath
package layer_pkg;

  localparam int T = 8;

  typedef logic signed [T-1:0] elem_t;

  typedef struct packed {
    logic  last;
    elem_t data;
  } fifo_word_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/act_fifo_relu.sv
// rtl/act_fifo_relu.sv - activation stage buffering layer output with vector last tagging
// ACT_FIFO_RELU_EN defined applies ReLU on write; undefined passes data through.
module act_fifo_relu
  import layer_pkg::*;
#(
  parameter int T       = layer_pkg::T,
  parameter int DEPTH   = 4,
  parameter int VEC_LEN = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [T-1:0]           data_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [T-1:0]           data_out,
  output logic                   m_last,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  logic             up;
  logic [IDX_W-1:0] idx;
  logic             last_tag;
  logic [T-1:0]     act_data;
  logic [T:0]       rd_word;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Holds s_ready low for the whole reset interval, not just until count settles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      up <= 1'b0;
    end else begin
      up <= 1'b1;
    end
  end

  assign s_ready  = up & ~full;
  assign m_valid  = ~empty;
  assign push     = s_valid & s_ready;
  assign pop      = m_valid & m_ready;
  assign last_tag = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx <= '0;
    end else if (push) begin
      idx <= last_tag ? '0 : idx + IDX_W'(1);
    end
  end

  always_comb begin
    act_data = data_in;
`ifdef ACT_FIFO_RELU_EN
    if (data_in[T-1]) begin
      act_data = '0;
    end
`endif
  end

  sync_fifo #(
    .WIDTH (T + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({last_tag, act_data}),
    .rd_en   (pop),
    .rd_data (rd_word),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign data_out = rd_word[T-1:0];
  assign m_last   = m_valid & rd_word[T];

endmodule

// File: tb/tb_act_fifo_relu.sv
// tb/tb_act_fifo_relu.sv - scoreboard bench for act_fifo_relu (DEPTH=4, VEC_LEN=2)
module tb_act_fifo_relu;

  localparam int T       = 8;
  localparam int DEPTH   = 4;
  localparam int VEC_LEN = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [T-1:0] data_in;
  logic         m_valid;
  logic         m_ready;
  logic [T-1:0] data_out;
  logic         m_last;
  logic [2:0]   count;

  always #5 clk = ~clk;

  act_fifo_relu #(
    .T       (T),
    .DEPTH   (DEPTH),
    .VEC_LEN (VEC_LEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .m_last   (m_last),
    .count    (count)
  );

  typedef struct {
    logic         last;
    logic [T-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           tb_idx   = 0;
  bit           accepted;
  logic [T-1:0] cur_exp;
  logic [T:0]   held;
  bit           held_v = 0;

  // Edge-value table: raw -128,-1,0,127 and their expected outputs per build.
  logic [T-1:0] edge_in [4] = '{8'h80, 8'hff, 8'h00, 8'h7f};
`ifdef ACT_FIFO_RELU_EN
  logic [T-1:0] edge_exp[4] = '{8'h00, 8'h00, 8'h00, 8'h7f};
`else
  logic [T-1:0] edge_exp[4] = '{8'h80, 8'hff, 8'h00, 8'h7f};
`endif

  function automatic logic [T-1:0] act_ref(input logic [T-1:0] x);
`ifdef ACT_FIFO_RELU_EN
    return x[T-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    accepted = 0;
    if (reset && s_valid && s_ready) begin
      e.last = (tb_idx == VEC_LEN - 1);
      e.data = cur_exp;
      exp_q.push_back(e);
      tb_idx   = (tb_idx == VEC_LEN - 1) ? 0 : tb_idx + 1;
      accepted = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [T-1:0] v, input logic [T-1:0] e);
    s_valid = 1'b1;
    data_in = v;
    cur_exp = e;
    for (int i = 0; i < 50; i++) begin
      step();
      if (accepted) break;
    end
    check("send_accept", 32'(accepted), 1);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!m_valid) break;
      step();
    end
    check("drain_empty", 32'(m_valid), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset !== 1'b1) begin
      held_v = 0;
    end else begin
      if (held_v && m_valid) begin
        check("hold_stable", 32'({m_last, data_out}), 32'(held));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(data_out), 32'(e.data));
          check("out_last", 32'(m_last), 32'(e.last));
        end
        held_v = 0;
      end else if (m_valid) begin
        held   = {m_last, data_out};
        held_v = 1;
      end else begin
        held_v = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = '0;
    cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last",  32'(m_last),  0);
    check("rst_count",   32'(count),   0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_s_ready", 32'(s_ready), 1);

    // Fill to full with the consumer stalled, then hold the fifth value upstream.
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 8'(i));
    check("t1_count_full", 32'(count), 4);
    check("t1_s_ready_full", 32'(s_ready), 0);
    s_valid = 1'b1;
    data_in = 8'd5;
    cur_exp = 8'd5;
    repeat (3) begin
      step();
      check("t1_held_upstream", 32'(accepted), 0);
      check("t1_count_held", 32'(count), 4);
    end

    // Full with s_valid and m_ready: only a pop, space appears next cycle.
    m_ready = 1'b1;
    step();
    check("t5_no_push", 32'(accepted), 0);
    check("t5_count", 32'(count), 3);
    check("t5_s_ready", 32'(s_ready), 1);
    step();
    check("t5_push_after", 32'(accepted), 1);
    check("t5_count_pp", 32'(count), 3);
    s_valid = 1'b0;
    drain();
    check("t1_count_empty", 32'(count), 0);

    // Signed edge values through the activation.
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(edge_in[i], edge_exp[i]);
    drain();

    // Simultaneous push and pop at count 2.
    m_ready = 1'b0;
    send(8'd10, 8'd10);
    send(8'd20, 8'd20);
    check("t4_count2", 32'(count), 2);
    m_ready = 1'b1;
    s_valid = 1'b1;
    data_in = 8'd30;
    cur_exp = 8'd30;
    step();
    check("t4_accept_a", 32'(accepted), 1);
    check("t4_count_a", 32'(count), 2);
    data_in = 8'd40;
    cur_exp = 8'd40;
    step();
    check("t4_accept_b", 32'(accepted), 1);
    check("t4_count_b", 32'(count), 2);
    s_valid = 1'b0;
    drain();

    // Reset mid-stream with three entries buffered.
    m_ready = 1'b0;
    send(8'd7, 8'd7);
    send(8'd8, 8'd8);
    send(8'd9, 8'd9);
    check("t6_count3", 32'(count), 3);
    reset = 1'b0;
    exp_q.delete();
    tb_idx = 0;
    step();
    check("t6_m_valid", 32'(m_valid), 0);
    check("t6_count", 32'(count), 0);
    check("t6_s_ready_held", 32'(s_ready), 0);
    check("t6_m_last", 32'(m_last), 0);
    reset = 1'b1;
    step();
    check("t6_s_ready_rel", 32'(s_ready), 1);

    // Vector tagging restarts at element 0 after reset: pattern 0,1,0,1,0,1.
    m_ready = 1'b0;
    send(8'd11, 8'd11);
    check("t3_first_last", 32'(m_last), 0);
    send(8'd12, 8'd12);
    check("t3_head_last", 32'(m_last), 0);
    m_ready = 1'b1;
    for (int i = 13; i <= 16; i++) send(8'(i), 8'(i));
    drain();

    // Randomized handshakes against the scoreboard.
    for (int i = 0; i < 80; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      cur_exp = act_ref(data_in);
      step();
    end
    s_valid = 1'b0;
    drain();

    check("final_queue_empty", 32'(exp_q.size()), 0);
    check("final_count", 32'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
